// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes, debounces and edge-detects N_KEYS active-low push-buttons.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   key            raw button pins, active-low (0 = pressed), asynchronous to clk
//   pressed        debounced level, 1 = held
//   press_pulse    1-cycle pulse on an accepted press
//   release_pulse  1-cycle pulse on an accepted release
//   strobe         press_pulse OR auto-repeat pulse, 1 cycle each
//
// Each key has its own synchronizer, FSM, debounce counter and repeat timer.
module key_debouncer #(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] strobe
);

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RtMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RtW   = $clog2(RtMax + 1);

  localparam logic [CntW-1:0] CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [RtW-1:0]  RtDelay  = RtW'(REPEAT_DELAY);
  localparam logic [RtW-1:0]  RtPeriod = RtW'(REPEAT_PERIOD);
  localparam logic [RtW-1:0]  RtOne    = RtW'(1);

  typedef enum logic [1:0] {StIdle, StPressChk, StHeld, StRelChk} state_e;

  // Two-flop synchronizer plus one retiming register, so the FSM input is a clean
  // registered "pressed" level. Flops reset to the released level.
  logic [N_KEYS-1:0] sync1_q, sync2_q, s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      s_q     <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      s_q     <= ~sync2_q;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RtW-1:0]  rt_q, rt_d;
    logic [RtW-1:0]  rt_inc, rt_target;
    logic            rep_q, rep_d;       // 1 once the first repeat has fired
    logic            pressed_q, pressed_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            strobe_q, strobe_d;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rt_d      = rt_q;
      rep_d     = rep_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      rel_d     = 1'b0;
      strobe_d  = 1'b0;
      rt_inc    = rt_q + RtOne;
      rt_target = rep_q ? RtPeriod : RtDelay;

      case (state_q)
        StIdle: begin
          if (s_q[i]) begin
            state_d = StPressChk;
            cnt_d   = CntOne;
          end
        end
        StPressChk: begin
          if (!s_q[i]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d   = StHeld;
            cnt_d     = '0;
            pressed_d = 1'b1;
            press_d   = 1'b1;
            strobe_d  = 1'b1;
            rt_d      = '0;
            rep_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StHeld: begin
          if (!s_q[i]) begin
            state_d = StRelChk;
            cnt_d   = CntOne;
          end else if (REPEAT_DELAY != 0) begin
            // Reload on each repeat so the timer never wraps into a spurious strobe.
            if (rt_inc == rt_target) begin
              strobe_d = 1'b1;
              rt_d     = '0;
              rep_d    = 1'b1;
            end else begin
              rt_d = rt_inc;
            end
          end
        end
        StRelChk: begin
          if (s_q[i]) begin
            // Release glitch: back to held, repeat cadence restarts from the delay.
            state_d = StHeld;
            cnt_d   = '0;
            rt_d    = '0;
            rep_d   = 1'b0;
          end else if (cnt_q == CntLast) begin
            state_d   = StIdle;
            cnt_d     = '0;
            pressed_d = 1'b0;
            rel_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        rt_q      <= '0;
        rep_q     <= 1'b0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        rel_q     <= 1'b0;
        strobe_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        rt_q      <= rt_d;
        rep_q     <= rep_d;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        rel_q     <= rel_d;
        strobe_q  <= strobe_d;
      end
    end

    assign pressed[i]       = pressed_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign strobe[i]        = strobe_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. A run-length reference model feeds a scoreboard queue every cycle;
// a segment table and hand-written sequences check the cycle-exact corner cases.
module tb_key_debouncer;
  localparam int unsigned NK = 3;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [NK-1:0] pressed, press_pulse, release_pulse, strobe;

  always #5 clk = ~clk;

  key_debouncer #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .strobe(strobe)
  );

  int asserts  = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] pressed;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] strobe;
  } out_t;

  out_t exp_q[$];

  // Reference model: key samples reach the decision point three edges after sampling;
  // a level flips after D consecutive samples that disagree with it.
  logic [2:0] hist [3];
  logic [2:0] m_lvl;
  int         m_run [3];
  int         m_hc  [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i]  = 3'b111;
      m_run[i] = 0;
      m_hc[i]  = 0;
    end
    m_lvl = 3'b000;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [2:0] kv, output out_t o);
    logic [2:0] s;
    s = ~hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = kv;
    o = '0;
    for (int i = 0; i < 3; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = s[i];
          m_run[i] = 0;
          m_hc[i]  = 0;
          if (s[i]) begin
            o.press[i]  = 1'b1;
            o.strobe[i] = 1'b1;
          end else begin
            o.rel[i] = 1'b1;
          end
        end
      end else if (m_run[i] > 0) begin
        m_run[i] = 0;
        if (m_lvl[i]) m_hc[i] = 0;
      end else if (m_lvl[i]) begin
        m_hc[i]++;
        if (m_hc[i] == RD || (m_hc[i] > RD && ((m_hc[i] - RD) % RP) == 0)) o.strobe[i] = 1'b1;
      end
    end
    o.pressed = m_lvl;
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_check();
    out_t e;
    asserts++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty: got no expected entry, required one at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("sb_pressed", pressed, e.pressed);
      chk("sb_press_pulse", press_pulse, e.press);
      chk("sb_release_pulse", release_pulse, e.rel);
      chk("sb_strobe", strobe, e.strobe);
    end
  endtask

  // Drive one key value for one clock; outputs are checked #1 after the rising edge.
  task automatic cycle(input logic [2:0] kv);
    out_t e;
    @(negedge clk);
    key = kv;
    model_edge(kv, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    sb_check();
  endtask

  typedef struct {
    logic [2:0] key;
    int         cycles;
    logic [2:0] pressed;
    logic [2:0] press_or;
    int         press_n;
    logic [2:0] rel_or;
    int         rel_n;
    logic [2:0] strobe_or;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    key = 3'b111;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pressed", pressed, 3'b000);
    chk("reset_press_pulse", press_pulse, 3'b000);
    chk("reset_release_pulse", release_pulse, 3'b000);
    chk("reset_strobe", strobe, 3'b000);
    rst = 1'b0;
    model_reset();

    // Key 0 held 12 cycles: pulse exactly in the cycle after edge 6.
    for (int i = 0; i < 12; i++) begin
      cycle(3'b110);
      chk("k0_press_pulse", {2'b00, press_pulse[0]}, {2'b00, (i == 6)});
      chk("k0_strobe", {2'b00, strobe[0]}, {2'b00, (i == 6)});
      chk("k0_pressed", {2'b00, pressed[0]}, {2'b00, (i >= 6)});
    end
    for (int i = 0; i < 8; i++) begin
      cycle(3'b111);
      chk("k0_release_pulse", {2'b00, release_pulse[0]}, {2'b00, (i == 6)});
      chk("k0_rel_pressed", {2'b00, pressed[0]}, {2'b00, (i < 6)});
    end

    // Segment table: key 1 bounce, then keys 0 and 2 together.
    vecs.push_back('{3'b101, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000});
    vecs.push_back('{3'b101, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000});
    vecs.push_back('{3'b111, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000});
    vecs.push_back('{3'b101, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000});
    vecs.push_back('{3'b111, 1, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000});
    vecs.push_back('{3'b111, 12, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000});
    vecs.push_back('{3'b010, 10, 3'b101, 3'b101, 1, 3'b000, 0, 3'b101});
    vecs.push_back('{3'b111, 10, 3'b000, 3'b000, 0, 3'b101, 1, 3'b000});
    for (int v = 0; v < vecs.size(); v++) begin
      logic [2:0] p_or, r_or, s_or;
      int         p_n, r_n;
      p_or = '0; r_or = '0; s_or = '0; p_n = 0; r_n = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        cycle(vecs[v].key);
        p_or |= press_pulse;
        r_or |= release_pulse;
        s_or |= strobe;
        if (press_pulse != 3'b000) p_n++;
        if (release_pulse != 3'b000) r_n++;
      end
      chk("vec_pressed", pressed, vecs[v].pressed);
      chk("vec_press_or", p_or, vecs[v].press_or);
      chk_int("vec_press_cycles", p_n, vecs[v].press_n);
      chk("vec_release_or", r_or, vecs[v].rel_or);
      chk_int("vec_release_cycles", r_n, vecs[v].rel_n);
      chk("vec_strobe_or", s_or, vecs[v].strobe_or);
    end

    // Key 2 auto-repeat: press at i=6 (P), repeats at P+20, +28, +36, +44.
    for (int i = 0; i < 57; i++) begin
      cycle(3'b011);
      chk("k2_strobe", {2'b00, strobe[2]},
          {2'b00, (i == 6 || i == 26 || i == 34 || i == 42 || i == 50)});
      chk("k2_press_pulse", {2'b00, press_pulse[2]}, {2'b00, (i == 6)});
    end
    // Release glitch of 2 cycles: the repeat due at j=1 still fires, HELD re-entered at
    // j=5, so the next repeat lands at j=25.
    for (int j = 0; j < 30; j++) begin
      cycle((j < 2) ? 3'b111 : 3'b011);
      chk("glitch_strobe", {2'b00, strobe[2]}, {2'b00, (j == 1 || j == 25)});
      chk("glitch_release", {2'b00, release_pulse[2]}, 3'b000);
      chk("glitch_pressed", {2'b00, pressed[2]}, 3'b001);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(3'b111);
      chk("k2_release_pulse", {2'b00, release_pulse[2]}, {2'b00, (i == 6)});
      chk("k2_rel_strobe", {2'b00, strobe[2]}, 3'b000);
    end

    // Reset while key 0 is held.
    for (int i = 0; i < 8; i++) cycle(3'b110);
    chk("pre_rst_pressed", pressed, 3'b001);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pressed", pressed, 3'b000);
    chk("async_rst_press_pulse", press_pulse, 3'b000);
    chk("async_rst_release_pulse", release_pulse, 3'b000);
    chk("async_rst_strobe", strobe, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst_release_pulse", release_pulse, 3'b000);
    chk("in_rst_pressed", pressed, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(3'b110);
      chk("post_rst_press_pulse", {2'b00, press_pulse[0]}, {2'b00, (i == 6)});
      chk("post_rst_release_pulse", release_pulse, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion before 100000");
    $fatal(1, "watchdog");
  end

endmodule
